// File: rtl/pipe_reg_chain.sv
// rtl/pipe_reg_chain.sv - elastic register pipeline with per-stage valid, bubble collapsing and flush
// Each stage loads from its predecessor whenever it is empty or the stage after it can move.

module pipe_reg_chain #(
  parameter int              WIDTH       = 8,
  parameter int              DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] d     [DEPTH];
  logic [WIDTH-1:0] src_d [DEPTH];
  logic             in_fire;
  logic             out_fire;

  // A stage can advance if the sink is ready or any stage from here to the output is empty.
  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_stage
      assign rdy[i] = out_ready || !(&v[DEPTH-1:i]);
      if (i == 0) begin : g_head
        assign src_v[i] = in_valid;
        assign src_d[i] = in_data;
      end else begin : g_body
        assign src_v[i] = v[i-1];
        assign src_d[i] = d[i-1];
      end
    end
  endgenerate

  assign in_ready  = rdy[0] && !flush && !reset;
  assign out_valid = v[DEPTH-1] && !flush && !reset;
  assign out_data  = d[DEPTH-1];
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v     <= '0;
      count <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d[k] <= RESET_VALUE;
      end
    end else if (flush) begin
      v     <= '0;
      count <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (rdy[k]) begin
          v[k] <= src_v[k];
          // Bubbles move through without disturbing the data registers.
          if (src_v[k]) begin
            d[k] <= src_d[k];
          end
        end
      end
      if (in_fire && !out_fire) begin
        count <= count + CW'(1);
      end else if (out_fire && !in_fire) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb/tb_pipe_reg_chain.sv - directed-vector bench for pipe_reg_chain (WIDTH=8, DEPTH=4)

module tb_pipe_reg_chain;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] count;

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] w;

  pipe_reg_chain #(
    .WIDTH      (8),
    .DEPTH      (4),
    .RESET_VALUE(8'hA5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;

    // Reset state and first-word latency
    #3;
    check("rst_out_data", out_data, 8'hA5);
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    tick();
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    in_valid  = 1'b1;
    in_data   = 8'h11;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("lat_not_yet", out_valid, 0);
      tick();
    end
    check("lat_out_valid", out_valid, 1);
    check("lat_out_data", out_data, 8'h11);
    check("lat_count", count, 1);
    tick();
    check("lat_drain_count", count, 0);

    // Streaming 0x00..0x0F with out_ready held high
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(k);
      #1;
      check("strm_in_ready", in_ready, 1);
      check("strm_count", count, (k < 4) ? k : 4);
      check("strm_out_valid", out_valid, (k >= 4) ? 1 : 0);
      if (k >= 4) check("strm_out_data", out_data, k - 4);
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("strm_drain_valid", out_valid, 1);
      check("strm_drain_data", out_data, 12 + k);
      tick();
    end
    check("strm_empty_count", count, 0);
    check("strm_empty_valid", out_valid, 0);

    // Stall and fill: 6 words offered, 4 fit
    out_ready = 1'b0;
    w = 8'h20;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_data  = w;
      #1;
      check("stall_in_ready", in_ready, (c < 4) ? 1 : 0);
      if (c >= 4) begin
        check("stall_count", count, 4);
        check("stall_out_data", out_data, 8'h20);
      end
      tick();
      if (c < 4) w = w + 8'd1;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_data = w;
      #1;
      check("full_pass_in_ready", in_ready, 1);
      check("full_pass_out_data", out_data, 8'h20 + k);
      tick();
      w = w + 8'd1;
    end
    check("full_pass_count", count, 4);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("stall_drain_valid", out_valid, 1);
      check("stall_drain_data", out_data, 8'h22 + k);
      tick();
    end
    check("stall_empty_count", count, 0);

    // Bubble collapse: two words with gaps, then two more while stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h30;
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    in_data  = 8'h31;
    tick();
    in_valid = 1'b0;
    #1;
    check("bub_count2", count, 2);
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_data  = 8'h32 + 8'(k);
      #1;
      check("bub_in_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("bub_count4", count, 4);
    check("bub_full_in_ready", in_ready, 0);
    check("bub_out_data", out_data, 8'h30);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("bub_drain_data", out_data, 8'h30 + k);
      tick();
    end
    check("bub_empty_count", count, 0);

    // Flush at count=3 with both handshakes requested
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 8'h40 + 8'(k);
      tick();
    end
    check("fl_pre_count", count, 3);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h43;
    out_ready = 1'b1;
    #1;
    check("fl_in_ready", in_ready, 0);
    check("fl_out_valid", out_valid, 0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("fl_count", count, 0);
    check("fl_out_valid_after", out_valid, 0);
    check("fl_data_kept", out_data, 8'h33);
    for (int k = 0; k < 4; k++) tick();
    check("fl_no_ghost", out_valid, 0);

    // Asynchronous reset between edges at count=3
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 8'h50 + 8'(k);
      tick();
    end
    in_valid = 1'b0;
    check("mr_pre_count", count, 3);
    #2;
    reset = 1'b1;
    #1;
    check("mr_count", count, 0);
    check("mr_out_valid", out_valid, 0);
    check("mr_out_data", out_data, 8'hA5);
    check("mr_in_ready", in_ready, 0);
    tick();
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("mr_no_old_data", out_valid, 0);
      tick();
    end
    in_valid = 1'b1;
    in_data  = 8'h60;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("mr_lat_not_yet", out_valid, 0);
      tick();
    end
    check("mr_lat_valid", out_valid, 1);
    check("mr_lat_data", out_data, 8'h60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
